// File: rtl/golay_pkg.sv
`default_nettype none
// ============================================================================
// Module   : golay_pkg
// Brief    : Shared constants, FSM state type and parity helper for the
//            extended Golay (24,12) encoder family.
// Revision : 1.0
// ============================================================================
package golay_pkg;

  localparam int DATA_W = 12;
  localparam int CW_W   = 24;

  // Entry i selects the data bits that feed parity bit i.
  localparam logic [DATA_W-1:0] P_MASK [0:11] = '{
    12'h477, 12'h8ED, 12'h1DB, 12'h3B5, 12'h769, 12'hED1,
    12'hDA3, 12'hB47, 12'h68F, 12'hD1D, 12'hA3B, 12'hFFE
  };

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } enc_state_e;

  function automatic logic [DATA_W-1:0] golay_parity(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] p;
    p = '0;
    for (int i = 0; i < DATA_W; i++) begin
      p[i] = ^(d & P_MASK[i]);
    end
    return p;
  endfunction

endpackage : golay_pkg
`default_nettype wire

// File: rtl/golay24_lane_enc.sv
`default_nettype none
// ============================================================================
// Module   : golay24_lane_enc
// Brief    : Combinational single-word extended Golay (24,12) encoder with
//            parity bypass; shared with the decoder's re-encode check.
// Revision : 1.0
// ============================================================================
module golay24_lane_enc
  import golay_pkg::*;
(
  input  logic [DATA_W-1:0] d,
  input  logic              parity_en,
  output logic [CW_W-1:0]   cw
);

  assign cw = {d, golay_parity(d) & {DATA_W{parity_en}}};

endmodule : golay24_lane_enc
`default_nettype wire

// File: rtl/golay_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module   : golay_stream_encoder
// Brief    : Multi-lane Golay (24,12) encoder with a group buffer serialised
//            onto a framed valid/ready stream, plus a codeword counter.
// Revision : 1.0
// ============================================================================
module golay_stream_encoder
  import golay_pkg::*;
#(
  parameter int LANES = 1,
  parameter int OUT_W = 24,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DATA_W*LANES-1:0]   s_data,
  input  logic                      s_parity_en,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [OUT_W-1:0]          m_data,
  output logic                      m_first,
  output logic                      m_last,
  output logic                      busy,
  output logic [CNT_W-1:0]          cw_count
);

  localparam int GRP_W  = CW_W * LANES;
  localparam int BEATS  = GRP_W / OUT_W;
  localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BSLOTS = 1 << BCNT_W;
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0]  CNT_INC   = CNT_W'(LANES);

  generate
    if (LANES < 1 || LANES > 8) begin : g_bad_lanes
      $error("golay_stream_encoder: LANES must be in 1..8");
    end
    if ((GRP_W % OUT_W) != 0) begin : g_bad_out_w
      $error("golay_stream_encoder: 24*LANES must be divisible by OUT_W");
    end
  endgenerate

  enc_state_e          state_q;
  logic [BCNT_W-1:0]   bcnt_q;
  logic [GRP_W-1:0]    grp_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [GRP_W-1:0]    w_grp_enc;
  logic [OUT_W-1:0]    w_beat [BSLOTS];
  logic                w_send;
  logic                w_last;

  // Lane 0 lands in the most significant codeword slot of the group.
  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      golay24_lane_enc u_enc (
        .d         (s_data[DATA_W*k +: DATA_W]),
        .parity_en (s_parity_en),
        .cw        (w_grp_enc[GRP_W-CW_W*(k+1) +: CW_W])
      );
    end

    for (genvar b = 0; b < BSLOTS; b++) begin : g_beat
      if (b < BEATS) begin : g_used
        assign w_beat[b] = grp_q[GRP_W-1-b*OUT_W -: OUT_W];
      end else begin : g_pad
        assign w_beat[b] = '0;
      end
    end
  endgenerate

  assign w_send   = (state_q == ST_SEND);
  assign w_last   = (bcnt_q == LAST_BEAT);

  // Accepting on the last-beat handshake reloads the buffer without a bubble.
  assign s_ready  = !w_send || (m_ready && w_last);
  assign m_valid  = w_send;
  assign busy     = w_send;
  assign m_data   = w_beat[bcnt_q];
  assign m_first  = w_send && (bcnt_q == '0);
  assign m_last   = w_send && w_last;
  assign cw_count = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bcnt_q  <= '0;
      grp_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (s_valid) begin
            grp_q   <= w_grp_enc;
            bcnt_q  <= '0;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (m_ready) begin
            if (w_last) begin
              cnt_q <= cnt_q + CNT_INC;
              if (s_valid) begin
                grp_q  <= w_grp_enc;
                bcnt_q <= '0;
              end else begin
                state_q <= ST_IDLE;
              end
            end else begin
              bcnt_q <= bcnt_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule : golay_stream_encoder
`default_nettype wire

// File: tb/tb_golay_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_golay_stream_encoder
// Brief    : Scoreboard bench for golay_stream_encoder in three configurations.
// Revision : 1.0
// ============================================================================
module tb_golay_stream_encoder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [23:0] d;
    logic        f;
    logic        l;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  exp_t ea, eb, ec;

  logic [11:0] TB_MASK [12] = '{12'h477, 12'h8ED, 12'h1DB, 12'h3B5, 12'h769, 12'hED1,
                                12'hDA3, 12'hB47, 12'h68F, 12'hD1D, 12'hA3B, 12'hFFE};

  // Instance A: LANES=1, OUT_W=24
  logic        a_s_valid = 1'b0, a_s_pe = 1'b1, a_m_ready = 1'b1;
  logic [11:0] a_s_data = '0;
  logic        a_s_ready, a_m_valid, a_m_first, a_m_last, a_busy;
  logic [23:0] a_m_data;
  logic [15:0] a_cnt;

  // Instance B: LANES=2, OUT_W=8
  logic        b_s_valid = 1'b0, b_s_pe = 1'b1, b_m_ready = 1'b1;
  logic [23:0] b_s_data = '0;
  logic        b_s_ready, b_m_valid, b_m_first, b_m_last, b_busy;
  logic [7:0]  b_m_data;
  logic [15:0] b_cnt;

  // Instance C: LANES=3, OUT_W=12
  logic        c_s_valid = 1'b0, c_s_pe = 1'b1, c_m_ready = 1'b1, c_rand = 1'b0;
  logic [35:0] c_s_data = '0;
  logic        c_s_ready, c_m_valid, c_m_first, c_m_last, c_busy;
  logic [11:0] c_m_data;
  logic [15:0] c_cnt;

  golay_stream_encoder #(.LANES(1), .OUT_W(24), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
    .s_parity_en(a_s_pe), .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
    .m_first(a_m_first), .m_last(a_m_last), .busy(a_busy), .cw_count(a_cnt));

  golay_stream_encoder #(.LANES(2), .OUT_W(8), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
    .s_parity_en(b_s_pe), .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
    .m_first(b_m_first), .m_last(b_m_last), .busy(b_busy), .cw_count(b_cnt));

  golay_stream_encoder #(.LANES(3), .OUT_W(12), .CNT_W(16)) u_c (
    .clk(clk), .rst_n(rst_n), .s_valid(c_s_valid), .s_ready(c_s_ready), .s_data(c_s_data),
    .s_parity_en(c_s_pe), .m_valid(c_m_valid), .m_ready(c_m_ready), .m_data(c_m_data),
    .m_first(c_m_first), .m_last(c_m_last), .busy(c_busy), .cw_count(c_cnt));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] ref_cw(input logic [11:0] d, input logic pe);
    logic [11:0] p;
    for (int i = 0; i < 12; i++) p[i] = pe & (^(d & TB_MASK[i]));
    return {d, p};
  endfunction

  task automatic push_exp(input int inst, input logic [23:0] d, input logic f, input logic l);
    exp_t e;
    e.d = d; e.f = f; e.l = l;
    if (inst == 0) qa.push_back(e);
    else if (inst == 1) qb.push_back(e);
    else qc.push_back(e);
  endtask

  // Hand-computed beats for lane0=0x001 (0x0017FF), lane1=0x800 (0x800EE2).
  task automatic push_b_std(input int n);
    logic [7:0] bytes [6];
    bytes = '{8'h00, 8'h17, 8'hFF, 8'h80, 8'h0E, 8'hE2};
    for (int i = 0; i < n; i++) push_exp(1, {16'h0, bytes[i]}, i == 0, i == 5);
  endtask

  task automatic send_a(input logic [11:0] d, input logic pe);
    int k;
    a_s_data = d; a_s_pe = pe; a_s_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!a_s_ready && k < 1000) begin @(negedge clk); k++; end
    if (!a_s_ready) chk("a_s_ready_timeout", 0, 1);
    @(posedge clk); #1 a_s_valid = 1'b0;
  endtask

  task automatic send_b(input logic [23:0] d);
    int k;
    b_s_data = d; b_s_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!b_s_ready && k < 1000) begin @(negedge clk); k++; end
    if (!b_s_ready) chk("b_s_ready_timeout", 0, 1);
    @(posedge clk); #1 b_s_valid = 1'b0;
  endtask

  task automatic send_c(input logic [35:0] d);
    int k;
    c_s_data = d; c_s_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!c_s_ready && k < 1000) begin @(negedge clk); k++; end
    if (!c_s_ready) chk("c_s_ready_timeout", 0, 1);
    @(posedge clk); #1 c_s_valid = 1'b0;
  endtask

  task automatic wait_drain(input int inst);
    int  k;
    logic pend;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (inst == 0) pend = (qa.size() != 0) || a_busy;
      else if (inst == 1) pend = (qb.size() != 0) || b_busy;
      else pend = (qc.size() != 0) || c_busy;
    end while (pend && k < 3000);
    if (pend) chk("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && a_m_valid && a_m_ready) begin
      if (qa.size() == 0) chk("a_unexpected_beat", 1, 0);
      else begin
        ea = qa.pop_front();
        chk("a_m_data", a_m_data, ea.d);
        chk("a_m_first", a_m_first, ea.f);
        chk("a_m_last", a_m_last, ea.l);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_m_valid && b_m_ready) begin
      if (qb.size() == 0) chk("b_unexpected_beat", 1, 0);
      else begin
        eb = qb.pop_front();
        chk("b_m_data", b_m_data, eb.d);
        chk("b_m_first", b_m_first, eb.f);
        chk("b_m_last", b_m_last, eb.l);
      end
    end
  end

  logic [11:0] c_hi;
  logic        c_half = 1'b0;
  int          c_wt;
  always @(negedge clk) begin
    if (rst_n && c_m_valid && c_m_ready) begin
      if (qc.size() == 0) chk("c_unexpected_beat", 1, 0);
      else begin
        ec = qc.pop_front();
        chk("c_m_data", c_m_data, ec.d);
        chk("c_m_first", c_m_first, ec.f);
        chk("c_m_last", c_m_last, ec.l);
      end
      if (!c_half) begin
        c_hi   = c_m_data;
        c_half = 1'b1;
      end else begin
        c_wt   = $countones({c_hi, c_m_data});
        chk("c_cw_weight", c_wt, ((c_wt == 0) || (c_wt == 8) || (c_wt == 12) ||
                                   (c_wt == 16) || (c_wt == 24)) ? c_wt : 99);
        c_half = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    c_m_ready = c_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] wd [3];
    logic [23:0] cw [3];
    logic [71:0] grp;

    // Reset state
    #3;
    chk("rst_m_valid_during_reset", a_m_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_s_ready", a_s_ready, 1);
    chk("rst_m_valid", a_m_valid, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_cw_count", a_cnt, 0);
    chk("rst_m_data", a_m_data, 0);
    chk("rst_m_first", a_m_first, 0);
    chk("rst_m_last", a_m_last, 0);
    chk("rst_b_m_valid", b_m_valid, 0);

    // Scenario 1: back-to-back single-lane words
    @(posedge clk); #1;
    a_s_valid = 1'b1; a_s_pe = 1'b1;
    wd = '{12'h000, 12'h001, 12'h800};
    push_exp(0, 24'h000000, 1, 1);
    push_exp(0, 24'h0017FF, 1, 1);
    push_exp(0, 24'h800EE2, 1, 1);
    for (int i = 0; i < 3; i++) begin
      a_s_data = wd[i];
      @(negedge clk);
      chk("s1_s_ready", a_s_ready, 1);
      if (i > 0) chk("s1_m_valid_consecutive", a_m_valid, 1);
      @(posedge clk); #1;
    end
    a_s_valid = 1'b0;
    @(negedge clk);
    chk("s1_m_valid_last", a_m_valid, 1);
    wait_drain(0);
    chk("s1_cw_count", a_cnt, 3);

    // Scenario 4: bypass then normal
    send_a(12'h800, 1'b0);
    push_exp(0, 24'h800000, 1, 1);
    wait_drain(0);
    chk("s4_cw_count_bypass", a_cnt, 4);
    push_exp(0, 24'h800EE2, 1, 1);
    send_a(12'h800, 1'b1);
    wait_drain(0);
    chk("s4_cw_count_normal", a_cnt, 5);

    // Scenario 2: two lanes into byte beats
    push_b_std(6);
    send_b({12'h800, 12'h001});
    wait_drain(1);
    chk("s2_cw_count", b_cnt, 2);

    // Scenario 3: stall on beat 2
    push_b_std(6);
    send_b({12'h800, 12'h001});
    @(posedge clk);
    @(posedge clk); #1;
    b_m_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("s3_hold_m_data", b_m_data, 8'hFF);
      chk("s3_hold_m_valid", b_m_valid, 1);
      chk("s3_stall_s_ready", b_s_ready, 0);
    end
    @(posedge clk); #1;
    b_m_ready = 1'b1;
    wait_drain(1);
    chk("s3_cw_count", b_cnt, 4);

    // Scenario 5: reset at beat 3
    push_b_std(3);
    send_b({12'h800, 12'h001});
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("s5_m_valid", b_m_valid, 0);
    chk("s5_busy", b_busy, 0);
    chk("s5_cw_count", b_cnt, 0);
    chk("s5_beats_consumed", qb.size(), 0);
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("s5_post_m_valid", b_m_valid, 0);
    @(posedge clk); #1;
    push_b_std(6);
    send_b({12'h800, 12'h001});
    wait_drain(1);
    chk("s5_cw_count_after", b_cnt, 2);

    // Scenario 6: random stress on three lanes
    c_rand = 1'b1;
    for (int g = 0; g < 24; g++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      for (int k = 0; k < 3; k++) begin
        wd[k] = 12'($urandom);
        cw[k] = ref_cw(wd[k], 1'b1);
      end
      grp = {cw[0], cw[1], cw[2]};
      for (int n = 0; n < 6; n++) begin
        push_exp(2, {12'h0, grp[71-12*n -: 12]}, n == 0, n == 5);
      end
      send_c({wd[2], wd[1], wd[0]});
    end
    wait_drain(2);
    c_rand = 1'b0;
    chk("s6_cw_count", c_cnt, 72);

    chk("end_qa_empty", qa.size(), 0);
    chk("end_qb_empty", qb.size(), 0);
    chk("end_qc_empty", qc.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_golay_stream_encoder
`default_nettype wire

// File: doc/golay_stream_encoder.md
Name: golay_stream_encoder

Overview:
- Sequential, parametrised successor to the team's combinational extended-Golay (24,12) encoder.
- Accepts LANES 12-bit data words per beat on a valid/ready input stream and registers their 24-bit codewords.
- Serialises the codewords onto an OUT_W-bit valid/ready output stream with first/last framing.
- Sits between the framer and the line interface; supports a per-beat parity-bypass mode and keeps a codeword counter.

Parameters:
- LANES, 1, number of 12-bit data words accepted per input beat (1..8).
- OUT_W, 24, output beat width. 24*LANES must be divisible by OUT_W; a violation is an elaboration-time error.
- CNT_W, 16, width of the codeword counter.

Ports:
- clk  in  1  clock. Rising edge is active.
- rst_n  in  1  reset, asynchronous, active-low.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat ready.
- s_data  in  12*LANES  data words. Lane k is s_data[12k+11:12k].
- s_parity_en  in  1  sampled with the beat. 1 = normal encode; 0 = parity field forced to zero (data-only bypass).
- m_valid  out  1  output beat valid.
- m_ready  in  1  output beat ready.
- m_data  out  OUT_W  output beat.
- m_first  out  1  first beat of a buffered group.
- m_last  out  1  last beat of a buffered group.
- busy  out  1  high while a group is buffered (state SEND).
- cw_count  out  CNT_W  total codewords emitted, wrapping.

Behaviour:
- Codeword per lane: cw[23:12] = d[11:0]; cw[11:0] = parity p. Each p[i] = XOR-reduce(d & P_MASK[i]), ANDed with s_parity_en.
- P_MASK[11..0] (hex) = FFE, A3B, D1D, 68F, B47, DA3, ED1, 769, 3B5, 1DB, 8ED, 477.
- Group buffer G (24*LANES bits) = {cw_lane0, cw_lane1, ..., cw_lane(L-1)}. Lane 0 occupies the MSBs.
- BEATS = 24*LANES/OUT_W. Beat n carries G[24*LANES-1-n*OUT_W -: OUT_W], so output is MSB first and lane 0 first.
- FSM states IDLE and SEND, with beat counter bcnt of width clog2(BEATS), minimum 1.
- IDLE: s_ready=1, m_valid=0. A handshake (s_valid & s_ready) loads G, sets bcnt=0 and moves to SEND.
- SEND: m_valid=1, m_data=beat[bcnt], m_first=(bcnt==0), m_last=(bcnt==BEATS-1).
  - Handshake on a non-last beat: bcnt+1.
  - Handshake on the last beat with s_valid=1: G reloads from the new beat, bcnt=0, state stays SEND. This gives zero-bubble throughput.
  - Handshake on the last beat with s_valid=0: state returns to IDLE.
- s_ready = (state==IDLE) | (state==SEND & m_ready & bcnt==BEATS-1). This is a combinational path from m_ready, and it is intentional.
- Latency: input accepted at edge t gives m_valid=1 with beat 0 after edge t, i.e. in the cycle following acceptance.
- Backpressure: while m_valid & !m_ready, m_data, m_first, m_last, G and bcnt hold stable. Input is stalled (s_ready=0) except in IDLE.
- When BEATS==1, m_first and m_last are both 1 on every beat.
- cw_count increments by LANES on each last-beat handshake. It wraps modulo 2^CNT_W, and bypass-mode groups are counted.
- Reset values: state=IDLE, bcnt=0, G=0, m_valid=0, m_first=0, m_last=0, m_data=0, busy=0, cw_count=0. s_ready=1 once rst_n is high.
- Reset asserted mid-group aborts the group immediately (asynchronously). Partial data is discarded and the group is never resumed.
- Outputs are don't-care-free: m_data is driven from G even when m_valid=0.

Decomposition:
- Package golay_pkg:
  - DATA_W=12, CW_W=24.
  - P_MASK[0:11] as 12-bit constants.
  - Function golay_parity(d), which returns 12 bits.
- Sub-module golay24_lane_enc (combinational, one per lane via generate): inputs d[11:0] and parity_en; output cw[23:0]. It is reused later by the decoder's re-encode check.
- Top level holds the FSM, group buffer, beat mux and counter.

Test Plan:
1. LANES=1, OUT_W=24, s_parity_en=1. Send 0x000, 0x001, 0x800 back-to-back with m_ready=1.
   - Required m_data: 0x000000, 0x0017FF, 0x800EE2 on consecutive cycles.
   - Required: s_ready stays 1 throughout, cw_count reaches 3.
2. LANES=2, OUT_W=8. One beat with lane0=0x001, lane1=0x800.
   - Required: 6 beats 0x00, 0x17, 0xFF, 0x80, 0x0E, 0xE2.
   - Required: m_first only on beat 0, m_last only on beat 5, cw_count=2.
3. Backpressure. Same as scenario 2 with m_ready low for 3 cycles at beat 2.
   - Required: m_data holds 0xFF, s_ready=0 during the stall, no beat lost or duplicated.
4. Bypass. s_parity_en=0, data 0x800.
   - Required: m_data=0x800000 and cw_count increments.
   - Then s_parity_en=1 with 0x800 gives 0x800EE2.
5. Reset mid-group. Drop rst_n at beat 3 of scenario 2.
   - Required immediately: m_valid=0, busy=0, cw_count=0.
   - After release, a new group 0x001/0x800 streams correctly from beat 0.
6. Random stress (LANES=3, OUT_W=12, random s_valid/m_ready).
   - Required: the scoreboard matches the golay_parity reference model.
   - Required: every emitted codeword has Hamming weight in {0, 8, 12, 16, 24}.
